// File: rtl/seq_detector_prog.sv
// seq_detector_prog: runtime-programmable serial sequence detector with overlap control and saturating match counter
//   CLK           clock, rising edge
//   RESET         synchronous active-high reset
//   x, x_valid    serial bit and its qualifier
//   load          latch pattern_in / len_in / overlap_in, clear history
//   pattern_in    pattern, bit len-1 received first, bit 0 last
//   len_in        pattern length (0 disables, clamped to PAT_W)
//   overlap_in    1 = overlapping matches allowed
//   clr_cnt       clear match counter (a same-cycle match counts as 1)
//   Z             registered match pulse (state == HIT)
//   match_cnt     saturating match count
//   current_state IDLE=00, HUNT=01, HIT=10
module seq_detector_prog #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8,
    localparam int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             x,
    input  logic             x_valid,
    input  logic             load,
    input  logic [PAT_W-1:0] pattern_in,
    input  logic [LEN_W-1:0] len_in,
    input  logic             overlap_in,
    input  logic             clr_cnt,
    output logic             Z,
    output logic [CNT_W-1:0] match_cnt,
    output logic [1:0]       current_state
);
    typedef enum logic [1:0] {IDLE = 2'b00, HUNT = 2'b01, HIT = 2'b10} state_t;
    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d, hist_q, hist_d, mask, w;
    logic [LEN_W-1:0] len_q, len_d, fill_q, fill_d, fill_inc, len_clamp;
    logic             ovl_q, ovl_d, fill_ok, match;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // w keeps only the newest PAT_W bits of {hist, x}; len never exceeds PAT_W
    assign w         = {hist_q[PAT_W-2:0], x};
    assign mask      = ~({PAT_W{1'b1}} << len_q);
    assign fill_inc  = (fill_q == LEN_W'(PAT_W)) ? fill_q : fill_q + 1'b1;
    assign fill_ok   = ((LEN_W+1)'(fill_q) + (LEN_W+1)'(1)) >= (LEN_W+1)'(len_q);
    assign len_clamp = (len_in > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : len_in;
    assign match     = !load && state_q != IDLE && x_valid && fill_ok && ((w ^ pat_q) & mask) == '0;

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        if (load) begin
            pat_d   = pattern_in;
            len_d   = len_clamp;
            ovl_d   = overlap_in;
            hist_d  = '0;
            fill_d  = '0;
            state_d = (len_clamp != '0) ? HUNT : IDLE;
        end else if (state_q != IDLE) begin
            state_d = match ? HIT : HUNT;
            if (x_valid) begin
                // a non-overlapping hit restarts the search from an empty history
                hist_d = (match && !ovl_q) ? '0 : w;
                fill_d = (match && !ovl_q) ? '0 : fill_inc;
            end
        end
        cnt_d = clr_cnt ? (match ? CNT_W'(1) : '0) : ((match && ~&cnt_q) ? cnt_q + 1'b1 : cnt_q);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            hist_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Z             = (state_q == HIT);
    assign match_cnt     = cnt_q;
    assign current_state = state_q;
endmodule
